// File: rtl/envelope_follower_pkg.sv
// rtl/envelope_follower_pkg.sv - shared constants and gate state encoding for the envelope follower
//
// Purpose : common definitions for the envelope follower slice.
//   ENV_FRAC_BITS  fractional bits of the 8.8 envelope register
//   ENV_MIN_STEP   smallest step applied while env != target
//   gate_state_t   gate FSM encoding (CLOSED / OPEN / HOLD)
// Ports   : none (package).

package envelope_follower_pkg;

  localparam int ENV_FRAC_BITS = 8;
  localparam int LEVEL_BITS    = 8;
  localparam int ENV_BITS      = LEVEL_BITS + ENV_FRAC_BITS;

  // A shifted step that rounds to zero would stall the envelope short of
  // its target, so at least this much is always applied.
  localparam logic [ENV_BITS-1:0] ENV_MIN_STEP = 16'd1;

  typedef enum logic [1:0] {
    GATE_CLOSED = 2'd0,
    GATE_OPEN   = 2'd1,
    GATE_HOLD   = 2'd2
  } gate_state_t;

  function automatic logic [LEVEL_BITS-1:0] min_level(input logic [LEVEL_BITS-1:0] x,
                                                      input logic [LEVEL_BITS-1:0] y);
    return (x < y) ? x : y;
  endfunction

endpackage

// File: rtl/envelope_follower_if.sv
// rtl/envelope_follower_if.sv - sample/control/result bundle of the envelope follower
//
// Purpose : groups the sample stream, smoothing/gate controls and results.
// Signals :
//   sample_valid, sample        one-cycle strobe + signed audio sample
//   a, r                        attack / release smoothing shifts
//   thresh_on, thresh_off, hold gate thresholds and hold time (samples)
//   amplitude, amp_valid        envelope byte and its update pulse
//   gate, gate_rise             detected gate and its rising-edge pulse
// Modports: master drives sample/controls, slave (the follower) drives results.

interface envelope_follower_if #(
  parameter int SAMPLE_BITS = 16,
  parameter int HOLD_BITS   = 12
);
  import envelope_follower_pkg::*;

  logic                          sample_valid;
  logic signed [SAMPLE_BITS-1:0] sample;
  logic [3:0]                    a;
  logic [3:0]                    r;
  logic [LEVEL_BITS-1:0]         thresh_on;
  logic [LEVEL_BITS-1:0]         thresh_off;
  logic [HOLD_BITS-1:0]          hold;
  logic [LEVEL_BITS-1:0]         amplitude;
  logic                          amp_valid;
  logic                          gate;
  logic                          gate_rise;

  modport master (
    output sample_valid, sample, a, r, thresh_on, thresh_off, hold,
    input  amplitude, amp_valid, gate, gate_rise
  );

  modport slave (
    input  sample_valid, sample, a, r, thresh_on, thresh_off, hold,
    output amplitude, amp_valid, gate, gate_rise
  );

endinterface

// File: rtl/envelope_follower_env_smoother.sv
// rtl/envelope_follower_env_smoother.sv - 8.8 envelope register with attack/release step smoothing
//
// Purpose : moves env toward {level, 8'h00} by (distance >> a) when rising
//           and (distance >> r) when falling, never less than ENV_MIN_STEP
//           and never past the target.
// Ports   :
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_valid          sample strobe; env updates on the following edge
//   i_level          8-bit target level
//   i_a, i_r         attack / release shifts (0 = instant)
//   o_env            envelope register (8.8)
//   o_amp_valid      one-cycle pulse, env was updated

module envelope_follower_env_smoother
  import envelope_follower_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [LEVEL_BITS-1:0] i_level,
  input  logic [3:0]            i_a,
  input  logic [3:0]            i_r,
  output logic [ENV_BITS-1:0]   o_env,
  output logic                  o_amp_valid
);

  logic [ENV_BITS-1:0] r_env;
  logic                r_amp_valid;

  logic [ENV_BITS-1:0] w_target;
  logic [ENV_BITS:0]   w_diff;
  logic                w_falling;
  logic [ENV_BITS-1:0] w_dist;
  logic [ENV_BITS-1:0] w_shifted;
  logic [ENV_BITS-1:0] w_step;
  logic [ENV_BITS-1:0] w_env_next;

  assign w_target  = {i_level, {ENV_FRAC_BITS{1'b0}}};
  // The extra bit of the difference is the direction: set when target < env.
  assign w_diff    = {1'b0, w_target} - {1'b0, r_env};
  assign w_falling = w_diff[ENV_BITS];
  assign w_dist    = w_falling ? (r_env - w_target) : w_diff[ENV_BITS-1:0];
  assign w_shifted = w_dist >> (w_falling ? i_r : i_a);
  // The step never exceeds w_dist, so the envelope lands on the target at worst.
  assign w_step    = (w_shifted == '0) ? ENV_MIN_STEP : w_shifted;

  always_comb begin
    w_env_next = r_env;
    if (w_dist != '0) begin
      w_env_next = w_falling ? (r_env - w_step) : (r_env + w_step);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_env       <= '0;
      r_amp_valid <= 1'b0;
    end else begin
      r_amp_valid <= i_valid;
      if (i_valid) begin
        r_env <= w_env_next;
      end
    end
  end

  assign o_env       = r_env;
  assign o_amp_valid = r_amp_valid;

endmodule

// File: rtl/envelope_follower.sv
// rtl/envelope_follower.sv - audio envelope follower with hysteresis/hold gate detector
//
// Purpose : rectifies and saturates the sample, smooths it into an 8-bit
//           envelope and runs a CLOSED/OPEN/HOLD gate detector on every
//           envelope update (gate moves two cycles after sample_valid).
// Ports   :
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   bus (slave)      sample stream, controls, amplitude/gate results

module envelope_follower
  import envelope_follower_pkg::*;
#(
  parameter int SAMPLE_BITS = 16,
  parameter int HOLD_BITS   = 12
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  envelope_follower_if.slave  bus
);

  localparam logic [SAMPLE_BITS-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_BITS-1){1'b0}}};

  // ---------------- magnitude ----------------
  logic [SAMPLE_BITS-1:0] w_neg;
  logic [SAMPLE_BITS-2:0] w_mag;
  logic [LEVEL_BITS-1:0]  w_level;

  assign w_neg = -bus.sample;
  // The most negative sample has no positive twin; clamp it to full scale.
  assign w_mag = !bus.sample[SAMPLE_BITS-1]   ? bus.sample[SAMPLE_BITS-2:0] :
                 (bus.sample == SAMPLE_MIN)   ? '1 :
                                                w_neg[SAMPLE_BITS-2:0];
  assign w_level = w_mag[SAMPLE_BITS-2 -: LEVEL_BITS];

  // ---------------- envelope ----------------
  logic [ENV_BITS-1:0]   w_env;
  logic                  w_amp_valid;
  logic [LEVEL_BITS-1:0] w_amplitude;

  envelope_follower_env_smoother u_env_smoother (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (bus.sample_valid),
    .i_level     (w_level),
    .i_a         (bus.a),
    .i_r         (bus.r),
    .o_env       (w_env),
    .o_amp_valid (w_amp_valid)
  );

  assign w_amplitude = w_env[ENV_BITS-1 -: LEVEL_BITS];

  // Bits that do not reach an output: the fraction and the magnitude LSBs.
  logic w_unused_bits;
  assign w_unused_bits = ^{w_neg[SAMPLE_BITS-1], w_mag, w_env[ENV_FRAC_BITS-1:0]};

  // ---------------- gate FSM ----------------
  gate_state_t           r_state;
  gate_state_t           w_state_next;
  logic [HOLD_BITS-1:0]  r_hold_cnt;
  logic [HOLD_BITS-1:0]  w_hold_cnt_next;
  logic                  r_gate_rise;
  logic                  w_gate_rise_next;
  logic [LEVEL_BITS-1:0] w_toff;

  // An off threshold above the on threshold would make the gate chatter.
  assign w_toff = min_level(bus.thresh_off, bus.thresh_on);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= GATE_CLOSED;
      r_hold_cnt  <= '0;
      r_gate_rise <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_gate_rise <= w_gate_rise_next;
    end
  end

  // Evaluated only on the cycle amp_valid is high, i.e. on the fresh amplitude.
  always_comb begin
    w_state_next     = r_state;
    w_hold_cnt_next  = r_hold_cnt;
    w_gate_rise_next = 1'b0;
    if (w_amp_valid) begin
      case (r_state)
        GATE_CLOSED: begin
          if (w_amplitude >= bus.thresh_on) begin
            w_state_next     = GATE_OPEN;
            w_gate_rise_next = 1'b1;
          end
        end
        GATE_OPEN: begin
          if (w_amplitude < w_toff) begin
            if (bus.hold != '0) begin
              w_state_next    = GATE_HOLD;
              w_hold_cnt_next = bus.hold;
            end else begin
              w_state_next = GATE_CLOSED;
            end
          end
        end
        GATE_HOLD: begin
          if (w_amplitude >= w_toff) begin
            w_state_next = GATE_OPEN;
          end else begin
            w_hold_cnt_next = r_hold_cnt - HOLD_BITS'(1);
            if (r_hold_cnt == HOLD_BITS'(1)) begin
              w_state_next = GATE_CLOSED;
            end
          end
        end
        default: begin
          w_state_next = GATE_CLOSED;
        end
      endcase
    end
  end

  assign bus.amplitude = w_amplitude;
  assign bus.amp_valid = w_amp_valid;
  assign bus.gate      = (r_state != GATE_CLOSED);
  assign bus.gate_rise = r_gate_rise;

endmodule

// File: tb/tb_envelope_follower.sv
// tb/tb_envelope_follower.sv - self-checking bench for envelope_follower

module tb_envelope_follower;

  localparam int SB = 16;
  localparam int HB = 12;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  envelope_follower_if #(.SAMPLE_BITS(SB), .HOLD_BITS(HB)) bus ();

  envelope_follower #(.SAMPLE_BITS(SB), .HOLD_BITS(HB)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus controls
  int p_a, p_r, p_on, p_off, p_hold;

  // reference model state
  int m_env, m_amp_valid, m_gate, m_rise, m_holding, m_rem;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int level_of(input int s);
    int m;
    m = (s < 0) ? -s : s;
    if (m > 32767) m = 32767;
    return m / 128;
  endfunction

  task automatic model_reset();
    m_env = 0; m_amp_valid = 0; m_gate = 0; m_rise = 0; m_holding = 0; m_rem = 0;
  endtask

  // One clock edge of the reference: the gate decision uses the amplitude
  // published by the previous edge, then the envelope takes the new sample.
  task automatic model_edge(input bit v, input int s);
    int amp, toff, target, step;
    m_rise = 0;
    if (m_amp_valid != 0) begin
      amp  = m_env / 256;
      toff = (p_off < p_on) ? p_off : p_on;
      if (m_gate == 0) begin
        if (amp >= p_on) begin m_gate = 1; m_rise = 1; m_holding = 0; end
      end else if (m_holding == 0) begin
        if (amp < toff) begin
          if (p_hold == 0) m_gate = 0;
          else begin m_holding = 1; m_rem = p_hold; end
        end
      end else begin
        if (amp >= toff) m_holding = 0;
        else begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin m_gate = 0; m_holding = 0; end
        end
      end
    end
    m_amp_valid = v ? 1 : 0;
    if (v) begin
      target = level_of(s) * 256;
      if (target > m_env) begin
        step = (target - m_env) >> p_a;
        if (step == 0) step = 1;
        m_env = m_env + step;
      end else if (target < m_env) begin
        step = (m_env - target) >> p_r;
        if (step == 0) step = 1;
        m_env = m_env - step;
      end
    end
  endtask

  task automatic drive_cycle(input bit v, input int s);
    logic signed [SB-1:0] s16;
    s16 = s[SB-1:0];
    bus.sample_valid = v;
    bus.sample       = s16;
    bus.a            = p_a[3:0];
    bus.r            = p_r[3:0];
    bus.thresh_on    = p_on[7:0];
    bus.thresh_off   = p_off[7:0];
    bus.hold         = p_hold[HB-1:0];
    @(posedge clk);
    model_edge(v, int'(s16));
    #1;
    check_val("amplitude", bus.amplitude, m_env / 256);
    check_val("amp_valid", bus.amp_valid, m_amp_valid);
    check_val("gate",      bus.gate,      m_gate);
    check_val("gate_rise", bus.gate_rise, m_rise);
    check_val("env",       dut.u_env_smoother.r_env, m_env);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bit loud;
    p_a = 0; p_r = 0; p_on = 255; p_off = 255; p_hold = 0;
    bus.sample_valid = 1'b0;
    bus.sample = '0;
    bus.a = '0; bus.r = '0; bus.thresh_on = 8'd255; bus.thresh_off = 8'd255; bus.hold = '0;
    model_reset();

    // reset state
    #2;
    check_val("rst_amplitude", bus.amplitude, 0);
    check_val("rst_amp_valid", bus.amp_valid, 0);
    check_val("rst_gate",      bus.gate,      0);
    check_val("rst_gate_rise", bus.gate_rise, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // instant attack, then amplitude holds without valid
    p_a = 0;
    drive_cycle(1, 16384);
    check_val("t1_amp", bus.amplitude, 128);
    check_val("t1_valid", bus.amp_valid, 1);
    repeat (3) drive_cycle(0, 0);
    check_val("t1_amp_held", bus.amplitude, 128);
    check_val("t1_valid_idle", bus.amp_valid, 0);
    drive_cycle(1, 0);
    drive_cycle(0, 0);

    // smoothed attack
    p_a = 2;
    drive_cycle(1, 16384);
    check_val("t2_env0", dut.u_env_smoother.r_env, 16'h2000);
    check_val("t2_amp0", bus.amplitude, 32);
    drive_cycle(1, 16384);
    check_val("t2_env1", dut.u_env_smoother.r_env, 16'h3800);
    check_val("t2_amp1", bus.amplitude, 56);
    drive_cycle(1, 16384);
    check_val("t2_env2", dut.u_env_smoother.r_env, 16'h4A00);
    check_val("t2_amp2", bus.amplitude, 74);

    // saturation of the most negative sample, instant release
    p_a = 0; p_r = 0;
    drive_cycle(1, -32768);
    check_val("t3_sat_amp", bus.amplitude, 255);
    drive_cycle(1, 0);
    check_val("t3_rel_amp", bus.amplitude, 0);
    repeat (2) drive_cycle(0, 0);

    // minimum step both ways
    p_a = 15;
    drive_cycle(1, 128);
    check_val("t4_minstep_up", dut.u_env_smoother.r_env, 1);
    p_r = 15;
    drive_cycle(1, 0);
    check_val("t4_minstep_dn", dut.u_env_smoother.r_env, 0);
    drive_cycle(0, 0);

    // gate with hold = 3
    p_a = 0; p_r = 0; p_on = 64; p_off = 32; p_hold = 3;
    drive_cycle(1, 16384);
    check_val("t5_gate_c1", bus.gate, 0);
    drive_cycle(1, 0);
    check_val("t5_gate_open", bus.gate, 1);
    check_val("t5_rise", bus.gate_rise, 1);
    drive_cycle(1, 0);
    check_val("t5_gate_drop", bus.gate, 1);
    check_val("t5_rise_once", bus.gate_rise, 0);
    drive_cycle(1, 0);
    drive_cycle(1, 0);
    check_val("t5_gate_hold2", bus.gate, 1);
    drive_cycle(1, 0);
    check_val("t5_gate_fall", bus.gate, 0);

    // hold = 0 closes on the drop evaluation
    p_hold = 0;
    drive_cycle(1, 16384);
    drive_cycle(1, 0);
    check_val("t6_gate_open", bus.gate, 1);
    drive_cycle(1, 0);
    check_val("t6_gate_fall", bus.gate, 0);

    // thresh_off above thresh_on acts as thresh_on
    p_off = 200;
    drive_cycle(1, 16384);
    drive_cycle(1, 12800);
    drive_cycle(1, 12800);
    check_val("t7_toff_open", bus.gate, 1);
    drive_cycle(1, 6400);
    drive_cycle(0, 0);
    check_val("t7_toff_close", bus.gate, 0);

    // asynchronous reset while in HOLD
    p_off = 32; p_hold = 3;
    drive_cycle(1, 16384);
    drive_cycle(1, 0);
    drive_cycle(1, 0);
    check_val("t8_in_hold", bus.gate, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t8_rst_amp",  bus.amplitude, 0);
    check_val("t8_rst_gate", bus.gate, 0);
    check_val("t8_rst_av",   bus.amp_valid, 0);
    check_val("t8_rst_rise", bus.gate_rise, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    p_a = 0;
    drive_cycle(1, 16384);
    check_val("t8_after_rst_amp", bus.amplitude, 128);

    // randomized run against the model
    loud = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (i % 64 == 0) begin
        p_a    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
        p_r    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
        p_on   = int'($urandom_range(0, 255));
        p_off  = int'($urandom_range(0, 255));
        p_hold = int'($urandom_range(0, 6));
      end
      if (i % 16 == 0) loud = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 49) == 0) s = -32768;
      else if (loud) s = int'($urandom_range(0, 65535)) - 32768;
      else s = int'($urandom_range(0, 2000)) - 1000;
      drive_cycle($urandom_range(0, 3) != 0, s);
    end
    drive_cycle(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
